// File: rtl/store_buffer_drain_ctrl_pkg.sv
// Shared types, defaults and helpers for the dcache store-buffer drain controller.
package store_buffer_drain_ctrl_pkg;

    localparam int unsigned SB_STARVE_LIMIT = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_buffer_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } sb_drain_state_t;

    // A pop needs an entry, no racing search, and either a free pipe or a reason to force.
    function automatic logic sb_pop_ok(
        input logic not_empty,
        input logic search_active,
        input logic flush_active,
        input logic full,
        input logic starve_hit,
        input logic pipe_busy
    );
        return not_empty & ~search_active & (flush_active | full | starve_hit | ~pipe_busy);
    endfunction

    function automatic logic sb_force_cond(
        input logic flush_active,
        input logic full,
        input logic starve_hit
    );
        return flush_active | full | starve_hit;
    endfunction

endpackage

// File: rtl/store_buffer_drain_ctrl_starve_cnt.sv
// Saturating idle-blocked cycle counter; hit flags a store that has waited LIMIT cycles.
module sb_drain_starve_cnt
    import store_buffer_drain_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = SB_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_hit;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear wins over increment, increment saturates at the limit.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter and registered hit flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_hit <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_hit <= (w_cnt_nxt == CNT_MAX);
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/store_buffer_drain_ctrl.sv
// Store-buffer drain scheduler: pops the oldest store and presents it to the dcache write port.
// Optional performance counters are built when SB_DRAIN_PERF_EN is defined.
module store_buffer_drain_ctrl
    import store_buffer_drain_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = SB_STARVE_LIMIT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sb_not_empty,
    input  logic          sb_full,
    input  store_buffer_t sb_oldest_info,
    input  logic          sb_search_active,
    output logic          sb_get_oldest,
    input  logic          dc_pipe_busy,
    output logic          dc_wr_valid,
    output store_buffer_t dc_wr_info,
    input  logic          dc_wr_ready,
    output logic          dc_wr_force,
    input  logic          flush_req,
    output logic          flush_done,
`ifdef SB_DRAIN_PERF_EN
    output logic [31:0]   perf_drained,
    output logic [31:0]   perf_forced,
    output logic [31:0]   perf_stall,
`endif
    output logic          drain_busy
);

    sb_drain_state_t r_state;
    store_buffer_t   r_info;
    logic            r_force;
    logic            r_flush_active;

    logic w_starve_hit;
    logic w_pop_ok;
    logic w_pop;
    logic w_accept;
    logic w_flush_done;
    logic w_starve_inc;
    logic w_starve_clr;

    sb_drain_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clock (clock),
        .reset (reset),
        .i_inc (w_starve_inc),
        .i_clr (w_starve_clr),
        .o_hit (w_starve_hit)
    );

    // Pop / accept decisions; the pop is held off while reset is asserted.
    always_comb begin
        w_pop_ok = sb_pop_ok(sb_not_empty, sb_search_active, r_flush_active,
                             sb_full, w_starve_hit, dc_pipe_busy);
        w_accept = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = 1'b0;
                w_pop    = w_pop_ok & reset;
            end
            WRITE: begin
                w_accept = dc_wr_ready;
                w_pop    = dc_wr_ready & w_pop_ok & reset;
            end
            default: begin
                w_accept = 1'b0;
                w_pop    = 1'b0;
            end
        endcase
        w_flush_done = r_flush_active & (r_state == IDLE) & ~sb_not_empty & ~w_pop;
        w_starve_inc = (r_state == IDLE) & sb_not_empty & ~w_pop;
        w_starve_clr = w_pop | ~sb_not_empty;
    end

    // Drain FSM, latched store, force flag and flush tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_info         <= '0;
            r_force        <= 1'b0;
            r_flush_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= WRITE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    if (dc_wr_ready && !w_pop) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WRITE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_pop) begin
                r_info  <= sb_oldest_info;
                r_force <= sb_force_cond(r_flush_active, sb_full, w_starve_hit);
            end
            // A request arriving on the completion edge is merged into the finishing flush.
            if (w_flush_done) begin
                r_flush_active <= 1'b0;
            end else if (flush_req) begin
                r_flush_active <= 1'b1;
            end
        end
    end

    assign sb_get_oldest = w_pop;
    assign dc_wr_valid   = (r_state == WRITE);
    assign dc_wr_info    = r_info;
    assign dc_wr_force   = (r_state == WRITE) & r_force;
    assign flush_done    = w_flush_done;
    assign drain_busy    = (r_state != IDLE) | r_flush_active;

`ifdef SB_DRAIN_PERF_EN
    logic [31:0] r_perf_drained;
    logic [31:0] r_perf_forced;
    logic [31:0] r_perf_stall;

    // Wrapping event counters for accepted, forced-accepted and stalled write cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_drained <= 32'd0;
            r_perf_forced  <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_perf_drained <= r_perf_drained + 32'd1;
            end
            if (w_accept && dc_wr_force) begin
                r_perf_forced <= r_perf_forced + 32'd1;
            end
            if (dc_wr_valid && !dc_wr_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_drained = r_perf_drained;
    assign perf_forced  = r_perf_forced;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_store_buffer_drain_ctrl.sv
// Bench for store_buffer_drain_ctrl: vector table, directed corner sequences, randomized run
// against a cycle-level reference model with a small store-buffer environment.
`timescale 1ns/1ps
module tb_store_buffer_drain_ctrl;
    import store_buffer_drain_ctrl_pkg::*;

    localparam int STARVE = SB_STARVE_LIMIT;
    localparam int DEPTH  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sb_not_empty = 1'b0;
    logic          sb_full = 1'b0;
    store_buffer_t sb_oldest_info = '0;
    logic          sb_search_active = 1'b0;
    logic          sb_get_oldest;
    logic          dc_pipe_busy = 1'b0;
    logic          dc_wr_valid;
    store_buffer_t dc_wr_info;
    logic          dc_wr_ready = 1'b0;
    logic          dc_wr_force;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          drain_busy;
`ifdef SB_DRAIN_PERF_EN
    logic [31:0]   perf_drained;
    logic [31:0]   perf_forced;
    logic [31:0]   perf_stall;
`endif

    store_buffer_drain_ctrl #(.STARVE_LIMIT(STARVE)) dut (
        .clock            (clock),
        .reset            (reset),
        .sb_not_empty     (sb_not_empty),
        .sb_full          (sb_full),
        .sb_oldest_info   (sb_oldest_info),
        .sb_search_active (sb_search_active),
        .sb_get_oldest    (sb_get_oldest),
        .dc_pipe_busy     (dc_pipe_busy),
        .dc_wr_valid      (dc_wr_valid),
        .dc_wr_info       (dc_wr_info),
        .dc_wr_ready      (dc_wr_ready),
        .dc_wr_force      (dc_wr_force),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
`ifdef SB_DRAIN_PERF_EN
        .perf_drained     (perf_drained),
        .perf_forced      (perf_forced),
        .perf_stall       (perf_stall),
`endif
        .drain_busy       (drain_busy)
    );

    always #5 clock = ~clock;

    // Environment: store buffer as a queue, updated on clock edges.
    store_buffer_t q[$];
    bit            push_req = 1'b0;
    store_buffer_t push_info = '0;

    // Reference model state.
    bit            m_pending, m_force, m_flush;
    store_buffer_t m_info;
    int            m_starve;
    int unsigned   p_drained, p_forced, p_stall;

    // Observations sampled at the falling edge.
    logic          o_pop, o_valid, o_force, o_done, o_busy;
    store_buffer_t o_info;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int n;
        bit busy, search, flush;
        bit e_pop, e_valid, e_force, e_done;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic store_buffer_t mk_info(input int k);
        store_buffer_t s;
        s.addr = 32'h1000_0000 + 32'(k * 4);
        s.data = $urandom;
        s.be   = 4'(k) ^ 4'hA;
        return s;
    endfunction

    task automatic drive_sb();
        sb_not_empty   = (q.size() != 0);
        sb_full        = (q.size() >= DEPTH);
        sb_oldest_info = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_force = 1'b0; m_flush = 1'b0;
        m_info = '0; m_starve = 0;
        p_drained = 0; p_forced = 0; p_stall = 0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        q.delete(); drive_sb();
        dc_pipe_busy = 1'b0; sb_search_active = 1'b0; dc_wr_ready = 1'b0;
        flush_req = 1'b0; push_req = 1'b0;
        model_reset();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // One clock: compare against the model at the falling edge, then advance model and buffer.
    task automatic tick();
        bit ne, full, hit, can, e_pop, e_done, idle, acc;
        @(negedge clock);
        ne     = sb_not_empty;
        full   = sb_full;
        hit    = (m_starve >= STARVE);
        can    = ne && !sb_search_active && (m_flush || full || hit || !dc_pipe_busy);
        e_pop  = m_pending ? (dc_wr_ready && can) : can;
        e_done = m_flush && !m_pending && !ne;
        o_pop = sb_get_oldest; o_valid = dc_wr_valid; o_info = dc_wr_info;
        o_force = dc_wr_force; o_done = flush_done; o_busy = drain_busy;
        chk("get_oldest", o_pop, e_pop);
        chk("wr_valid", o_valid, m_pending);
        if (m_pending) chk("wr_info", o_info, m_info);
        chk("wr_force", o_force, m_pending && m_force);
        chk("flush_done", o_done, e_done);
        chk("drain_busy", o_busy, m_pending || m_flush);
`ifdef SB_DRAIN_PERF_EN
        chk("perf_drained", perf_drained, p_drained);
        chk("perf_forced", perf_forced, p_forced);
        chk("perf_stall", perf_stall, p_stall);
`endif
        @(posedge clock);
        idle = !m_pending;
        acc  = m_pending && dc_wr_ready;
        if (acc) p_drained++;
        if (acc && m_force) p_forced++;
        if (m_pending && !dc_wr_ready) p_stall++;
        if (e_pop) begin
            m_info = sb_oldest_info; m_force = m_flush || full || hit; m_pending = 1'b1;
        end else if (acc) begin
            m_pending = 1'b0;
        end
        if (e_pop || !ne) m_starve = 0;
        else if (idle) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
        if (e_done) m_flush = 1'b0;
        else if (flush_req) m_flush = 1'b1;
        if (o_pop && q.size() != 0) void'(q.pop_front());
        if (push_req && q.size() < DEPTH) q.push_back(push_info);
        #1;
        drive_sb();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        store_buffer_t e;
        store_buffer_t ex[4];
        int first_pop, forced, dones, done_at;

        //          n  bsy srch fl   pop vld frc done
        vt[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Outputs while reset is held.
        #3;
        chk("rst_get_oldest", sb_get_oldest, 1'b0);
        chk("rst_valid", dc_wr_valid, 1'b0);
        chk("rst_info", dc_wr_info, 68'd0);
        chk("rst_force", dc_wr_force, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_busy", drain_busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            for (int k = 0; k < vt[i].n; k++) q.push_back(mk_info(i * 16 + k));
            drive_sb();
            dc_pipe_busy = vt[i].busy; sb_search_active = vt[i].search;
            flush_req = vt[i].flush; dc_wr_ready = 1'b0;
            tick();
            chk($sformatf("vec%0d_pop", i), o_pop, vt[i].e_pop);
            flush_req = 1'b0; dc_pipe_busy = 1'b1; sb_search_active = 1'b0;
            tick();
            chk($sformatf("vec%0d_valid", i), o_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_force", i), o_force, vt[i].e_force);
            chk($sformatf("vec%0d_done", i), o_done, vt[i].e_done);
        end

        // Single store: pop at t, valid at t+1, idle at t+2.
        do_reset();
        q.push_back(mk_info(100)); e = q[0]; drive_sb();
        dc_pipe_busy = 1'b0; dc_wr_ready = 1'b1;
        tick(); chk("t1_pop", o_pop, 1'b1); chk("t1_valid_t", o_valid, 1'b0);
        tick(); chk("t1_valid_t1", o_valid, 1'b1); chk("t1_info", o_info, e);
        tick(); chk("t1_valid_t2", o_valid, 1'b0); chk("t1_busy_t2", o_busy, 1'b0);

        // Four entries back-to-back with ready held.
        do_reset();
        for (int k = 0; k < 4; k++) begin ex[k] = mk_info(200 + k); q.push_back(ex[k]); end
        drive_sb();
        dc_pipe_busy = 1'b0; dc_wr_ready = 1'b1;
        tick(); chk("t2_pop", o_pop, 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("t2_valid%0d", j), o_valid, 1'b1);
            chk($sformatf("t2_info%0d", j), o_info, ex[j]);
        end
        tick(); chk("t2_valid_end", o_valid, 1'b0);
`ifdef SB_DRAIN_PERF_EN
        chk("t2_perf_drained", perf_drained, 32'd4);
`endif

        // Starvation: pipe busy forever, pop on the 17th blocked cycle, forced.
        do_reset();
        q.push_back(mk_info(300)); drive_sb();
        dc_pipe_busy = 1'b1; dc_wr_ready = 1'b0;
        first_pop = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (o_pop && first_pop < 0) first_pop = c;
        end
        chk("t3_pop_cycle", first_pop, 17);
        chk("t3_force", o_force, 1'b1);
        dc_wr_ready = 1'b1; tick(); tick();

        // Full buffer with busy pipe: immediate pop, three stall cycles, stable info.
        do_reset();
        for (int k = 0; k < 4; k++) begin ex[k] = mk_info(400 + k); q.push_back(ex[k]); end
        drive_sb();
        dc_pipe_busy = 1'b1; dc_wr_ready = 1'b0;
        tick(); chk("t4_pop", o_pop, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("t4_valid%0d", j), o_valid, 1'b1);
            chk($sformatf("t4_info%0d", j), o_info, ex[0]);
            chk($sformatf("t4_force%0d", j), o_force, 1'b1);
        end
        dc_wr_ready = 1'b1;
        tick(); chk("t4_accept_valid", o_valid, 1'b1);
`ifdef SB_DRAIN_PERF_EN
        chk("t4_perf_stall", perf_stall, 32'd3);
`endif
        dc_wr_ready = 1'b0; tick();

        // Flush of three entries under a busy pipe, then a flush of an empty buffer.
        do_reset();
        for (int k = 0; k < 3; k++) q.push_back(mk_info(500 + k));
        drive_sb();
        dc_pipe_busy = 1'b1; dc_wr_ready = 1'b1; flush_req = 1'b1;
        tick(); flush_req = 1'b0;
        forced = 0; dones = 0; done_at = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (o_valid && o_force) forced++;
            if (o_done) begin dones++; done_at = c; end
        end
        chk("t5_forced_writes", forced, 3);
        chk("t5_done_count", dones, 1);
        chk("t5_done_cycle", done_at, 5);
        flush_req = 1'b1; tick(); chk("t5_empty_done_t", o_done, 1'b0);
        flush_req = 1'b0; tick(); chk("t5_empty_done_t1", o_done, 1'b1);
        tick(); chk("t5_empty_done_t2", o_done, 1'b0); chk("t5_busy_end", o_busy, 1'b0);

        // Search blocks the pop for exactly that cycle; then reset mid-write.
        do_reset();
        q.push_back(mk_info(600)); drive_sb();
        dc_pipe_busy = 1'b0; dc_wr_ready = 1'b0; sb_search_active = 1'b1;
        tick(); chk("t6_pop_blocked", o_pop, 1'b0);
        sb_search_active = 1'b0;
        tick(); chk("t6_pop", o_pop, 1'b1);
        tick(); chk("t6_valid", o_valid, 1'b1);
        reset = 1'b0; q.delete(); drive_sb(); model_reset();
        #2;
        chk("t6_rst_valid", dc_wr_valid, 1'b0);
        chk("t6_rst_info", dc_wr_info, 68'd0);
        chk("t6_rst_force", dc_wr_force, 1'b0);
        chk("t6_rst_busy", drain_busy, 1'b0);
        chk("t6_rst_pop", sb_get_oldest, 1'b0);

        // Randomized traffic against the model, alternating light and heavy load phases.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            dc_pipe_busy     = ($urandom_range(99) < (((cyc / 500) % 2 == 1) ? 95 : 40));
            sb_search_active = ($urandom_range(99) < 10);
            dc_wr_ready      = ($urandom_range(99) < 60);
            flush_req        = ($urandom_range(199) < 3);
            push_req         = ($urandom_range(99) < 40);
            push_info        = mk_info(1000 + cyc);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
